// File: rtl/parity_check_rx.sv
// parity_check_rx: serial even-parity receiver.
// Collects DATA_W data bits (LSB first) plus a trailing parity bit and checks
// that the XOR over all DATA_W+1 bits is zero. Each word is delivered through
// a one-entry valid/ready output register. A saturating counter tracks bad frames.
// A second completed frame that finds the output slot busy is parked in a hold
// register. The receiver stalls until the slot drains.
// Optional build macro: PARITY_CHECK_RX_DROP_BAD_EN. When it is defined, bad
// frames are counted but never delivered, and m_perr is tied low.
module parity_check_rx #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_bit,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              frame_abort,
  output logic [DATA_W-1:0] m_data,
  output logic              m_perr,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  err_cnt,
  input  logic              cnt_clr
);

  localparam int BC_W = $clog2(DATA_W + 1);
  localparam logic [BC_W-1:0] PAR_IDX = BC_W'(DATA_W);

  typedef enum logic {COLLECT, STALL} state_t;

  state_t            state;
  state_t            state_next;
  logic [BC_W-1:0]   bit_cnt;
  logic [DATA_W-1:0] shift;
  logic              acc;
  logic [DATA_W-1:0] hold_data;
  logic [DATA_W-1:0] data_r;
  logic              valid_r;
  logic [CNT_W-1:0]  cnt_r;
`ifndef PARITY_CHECK_RX_DROP_BAD_EN
  logic              hold_perr;
  logic              perr_r;
`endif

  logic accept;
  logic complete;
  logic frame_bad;
  logic drain;
  logic slot_free;
  logic deliver;
  logic load_new;
  logic to_stall;
  logic load_held;
  logic cnt_inc;

  assign s_ready   = (state == COLLECT);
  assign accept    = s_valid & s_ready & ~frame_abort;
  assign complete  = accept & (bit_cnt == PAR_IDX);
  assign frame_bad = acc ^ s_bit;
  assign drain     = valid_r & m_ready;
  assign slot_free = ~valid_r | m_ready;
`ifdef PARITY_CHECK_RX_DROP_BAD_EN
  assign deliver   = complete & ~frame_bad;
`else
  assign deliver   = complete;
`endif
  assign load_new  = deliver & slot_free;
  assign to_stall  = deliver & ~slot_free;
  assign load_held = (state == STALL) & drain & ~frame_abort;
  assign cnt_inc   = complete & frame_bad;

  assign m_data  = data_r;
  assign m_valid = valid_r;
  assign err_cnt = cnt_r;
`ifdef PARITY_CHECK_RX_DROP_BAD_EN
  assign m_perr  = 1'b0;
`else
  assign m_perr  = perr_r;
`endif

  // State register for the collect/stall controller.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_next;
  end

  // Next state: park in STALL when a completed frame finds the slot busy, leave on drain or abort.
  always_comb begin
    state_next = state;
    case (state)
      COLLECT: if (to_stall) state_next = STALL;
      STALL:   if (frame_abort || drain) state_next = COLLECT;
      default: state_next = COLLECT;
    endcase
  end

  // Bit collection: shift data bits in from the top so the first bit lands at the LSB.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bit_cnt <= '0;
      shift   <= '0;
      acc     <= 1'b0;
    end else if (frame_abort) begin
      bit_cnt <= '0;
      acc     <= 1'b0;
    end else if (accept) begin
      if (bit_cnt == PAR_IDX) begin
        bit_cnt <= '0;
        acc     <= 1'b0;
      end else begin
        shift   <= {s_bit, shift[DATA_W-1:1]};
        bit_cnt <= bit_cnt + 1'b1;
        acc     <= acc ^ s_bit;
      end
    end
  end

  // Hold register: captures a completed frame that could not enter the busy output slot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_data <= '0;
`ifndef PARITY_CHECK_RX_DROP_BAD_EN
      hold_perr <= 1'b0;
`endif
    end else if (to_stall) begin
      hold_data <= shift;
`ifndef PARITY_CHECK_RX_DROP_BAD_EN
      hold_perr <= frame_bad;
`endif
    end
  end

  // Output slot: load a fresh or held frame, otherwise drop valid once the consumer takes it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_r  <= '0;
      valid_r <= 1'b0;
`ifndef PARITY_CHECK_RX_DROP_BAD_EN
      perr_r  <= 1'b0;
`endif
    end else if (load_new) begin
      data_r  <= shift;
      valid_r <= 1'b1;
`ifndef PARITY_CHECK_RX_DROP_BAD_EN
      perr_r  <= frame_bad;
`endif
    end else if (load_held) begin
      data_r  <= hold_data;
      valid_r <= 1'b1;
`ifndef PARITY_CHECK_RX_DROP_BAD_EN
      perr_r  <= hold_perr;
`endif
    end else if (drain) begin
      valid_r <= 1'b0;
    end
  end

  // Bad-frame counter: saturates at all-ones; a clear that meets an increment leaves 1.
  always_ff @(posedge clk) begin
    if (!rst_n)                  cnt_r <= '0;
    else if (cnt_clr)            cnt_r <= CNT_W'(cnt_inc);
    else if (cnt_inc && !(&cnt_r)) cnt_r <= cnt_r + 1'b1;
  end

endmodule
